// File: rtl/pipe_stage_buf.sv
// Multi-lane pipeline stage register with a valid/ready handshake, optional
// 2-entry skid buffer, synchronous flush and a saturating stall counter.

module pipe_stage_lane #(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_vld,
    input  logic [DATA_W-1:0] in_data,
    input  logic              ld_main_in,
    input  logic              ld_main_skid,
    input  logic              ld_skid_in,
    input  logic              clr_main,
    input  logic              clr_skid,
    output logic              out_vld,
    output logic [DATA_W-1:0] out_data
);
    logic              main_vld_q, main_vld_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic              skid_vld_q, skid_vld_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;

    always_comb begin
        main_vld_d  = main_vld_q;
        main_data_d = main_data_q;
        skid_vld_d  = skid_vld_q;
        skid_data_d = skid_data_q;
        if (ld_main_in) begin
            main_vld_d  = in_vld;
            main_data_d = in_data;
        end else if (ld_main_skid) begin
            main_vld_d  = skid_vld_q;
            main_data_d = skid_data_q;
        end
        if (clr_main) main_vld_d = 1'b0;
        if (ld_skid_in) begin
            skid_vld_d  = in_vld;
            skid_data_d = in_data;
        end
        if (clr_skid) skid_vld_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_vld_q  <= 1'b0;
            main_data_q <= '0;
            skid_vld_q  <= 1'b0;
            skid_data_q <= '0;
        end else begin
            main_vld_q  <= main_vld_d;
            main_data_q <= main_data_d;
            skid_vld_q  <= skid_vld_d;
            skid_data_q <= skid_data_d;
        end
    end

    assign out_vld  = main_vld_q;
    assign out_data = main_data_q;
endmodule

module pipe_stage_buf #(
    parameter int DATA_W = 64,
    parameter int LANES  = 1,
    parameter int SKID   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic [LANES-1:0]        in_valid,
    input  logic [LANES*DATA_W-1:0] in_data,
    output logic                    in_ready,
    output logic [LANES-1:0]        out_valid,
    output logic [LANES*DATA_W-1:0] out_data,
    input  logic                    out_ready,
    output logic [31:0]             stall_cnt
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

    state_e      state_q, state_d;
    logic        in_ready_q, in_ready_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic        in_fire, out_fire;
    logic        ld_main_in, ld_main_skid, ld_skid_in, clr_main, clr_skid;

    // Without the skid entry, ready must see out_ready directly to keep full rate.
    assign in_ready = (SKID != 0) ? in_ready_q : ((state_q == EMPTY) | out_ready);
    assign in_fire  = (|in_valid) & in_ready & ~flush;
    assign out_fire = (|out_valid) & out_ready & ~flush;

    always_comb begin
        state_d      = state_q;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid_in   = 1'b0;
        clr_main     = 1'b0;
        clr_skid     = 1'b0;
        if (flush) begin
            state_d  = EMPTY;
            clr_main = 1'b1;
            clr_skid = 1'b1;
        end else begin
            case (state_q)
                EMPTY: if (in_fire) begin
                    state_d    = ONE;
                    ld_main_in = 1'b1;
                end
                ONE: begin
                    if (in_fire && (out_fire || SKID == 0)) begin
                        ld_main_in = 1'b1;
                    end else if (in_fire) begin
                        state_d    = TWO;
                        ld_skid_in = 1'b1;
                    end else if (out_fire) begin
                        state_d  = EMPTY;
                        clr_main = 1'b1;
                    end
                end
                TWO: if (out_fire) begin
                    state_d      = ONE;
                    ld_main_skid = 1'b1;
                    clr_skid     = 1'b1;
                end
                default: state_d = EMPTY;
            endcase
        end
        in_ready_d = (state_d != TWO);
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((|out_valid) && !out_ready && !flush && !(&stall_cnt_q))
            stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        pipe_stage_lane #(.DATA_W(DATA_W)) u_lane (
            .clk         (clk),
            .rst         (rst),
            .in_vld      (in_valid[i]),
            .in_data     (in_data[i*DATA_W +: DATA_W]),
            .ld_main_in  (ld_main_in),
            .ld_main_skid(ld_main_skid),
            .ld_skid_in  (ld_skid_in),
            .clr_main    (clr_main),
            .clr_skid    (clr_skid),
            .out_vld     (out_valid[i]),
            .out_data    (out_data[i*DATA_W +: DATA_W])
        );
    end
endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: SKID=1 and SKID=0 instances, 2 lanes of
// 8 bits, with a queue scoreboard per instance checking every output handshake.

module tb_pipe_stage_buf;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        a_flush, a_in_ready, a_out_ready;
    logic [1:0]  a_in_valid, a_out_valid;
    logic [15:0] a_in_data, a_out_data;
    logic [31:0] a_stall;

    logic        b_flush, b_in_ready, b_out_ready;
    logic [1:0]  b_in_valid, b_out_valid;
    logic [15:0] b_in_data, b_out_data;
    logic [31:0] b_stall;

    pipe_stage_buf #(.DATA_W(8), .LANES(2), .SKID(1)) u_a (
        .clk(clk), .rst(rst), .flush(a_flush),
        .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
        .out_valid(a_out_valid), .out_data(a_out_data), .out_ready(a_out_ready),
        .stall_cnt(a_stall)
    );

    pipe_stage_buf #(.DATA_W(8), .LANES(2), .SKID(0)) u_b (
        .clk(clk), .rst(rst), .flush(b_flush),
        .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
        .out_valid(b_out_valid), .out_data(b_out_data), .out_ready(b_out_ready),
        .stall_cnt(b_stall)
    );

    typedef struct {
        logic [1:0]  v;
        logic [15:0] d;
    } item_t;

    item_t qa[$];
    item_t qb[$];
    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitors: expected bundles enter on input handshake, leave on output handshake.
    item_t ea;
    logic [15:0] ma;
    always @(negedge clk) if (!rst) begin
        if (a_flush) qa.delete();
        else begin
            if ((|a_out_valid) && a_out_ready) begin
                if (qa.size() == 0) begin
                    checks++;
                    $display("FAIL a_sb_unexpected: got %0h, expected nothing", a_out_data);
                end else begin
                    ea = qa.pop_front();
                    ma = {{8{ea.v[1]}}, {8{ea.v[0]}}};
                    chk("a_sb_valid", 32'(a_out_valid), 32'(ea.v));
                    chk("a_sb_data", 32'(a_out_data & ma), 32'(ea.d & ma));
                end
            end
            if ((|a_in_valid) && a_in_ready) qa.push_back('{a_in_valid, a_in_data});
        end
    end

    item_t eb;
    logic [15:0] mb;
    always @(negedge clk) if (!rst) begin
        if (b_flush) qb.delete();
        else begin
            if ((|b_out_valid) && b_out_ready) begin
                if (qb.size() == 0) begin
                    checks++;
                    $display("FAIL b_sb_unexpected: got %0h, expected nothing", b_out_data);
                end else begin
                    eb = qb.pop_front();
                    mb = {{8{eb.v[1]}}, {8{eb.v[0]}}};
                    chk("b_sb_valid", 32'(b_out_valid), 32'(eb.v));
                    chk("b_sb_data", 32'(b_out_data & mb), 32'(eb.d & mb));
                end
            end
            if ((|b_in_valid) && b_in_ready) qb.push_back('{b_in_valid, b_in_data});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1);
    end

    logic       b_or  [8] = '{1, 0, 1, 0, 1, 0, 1, 0};
    logic       b_iv  [8] = '{1, 1, 1, 1, 1, 0, 0, 0};
    logic [15:0] b_dat[8] = '{16'h0102, 16'h0304, 16'h0304, 16'h0506, 16'h0506, 0, 0, 0};
    logic       b_rdy [8] = '{1, 0, 1, 0, 1, 0, 1, 1};

    initial begin
        rst = 1'b1;
        a_flush = 0; a_in_valid = 0; a_in_data = 0; a_out_ready = 0;
        b_flush = 0; b_in_valid = 0; b_in_data = 0; b_out_ready = 0;
        @(negedge clk);
        chk("rst_a_out_valid", 32'(a_out_valid), 0);
        chk("rst_a_out_data", 32'(a_out_data), 0);
        chk("rst_a_in_ready", 32'(a_in_ready), 1);
        chk("rst_a_stall", a_stall, 0);
        chk("rst_b_out_valid", 32'(b_out_valid), 0);
        tick(); tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_a_valid", 32'(a_out_valid), 0);
        chk("post_rst_a_ready", 32'(a_in_ready), 1);

        // streaming, one bundle per cycle
        tick(); a_out_ready = 1; a_in_valid = 2'b11; a_in_data = 16'h1111;
        @(negedge clk); chk("str_rdy0", 32'(a_in_ready), 1); chk("str_lat", 32'(a_out_valid), 0);
        tick(); a_in_data = 16'h2222;
        @(negedge clk); chk("str_rdy1", 32'(a_in_ready), 1); chk("str_out1", 32'(a_out_data), 16'h1111);
        tick(); a_in_data = 16'h3333;
        @(negedge clk); chk("str_rdy2", 32'(a_in_ready), 1); chk("str_out2", 32'(a_out_data), 16'h2222);
        tick(); a_in_valid = 0;
        @(negedge clk); chk("str_out3", 32'(a_out_data), 16'h3333); chk("str_v3", 32'(a_out_valid), 3);
        tick();
        @(negedge clk); chk("str_drain", 32'(a_out_valid), 0); chk("str_stall", a_stall, 0);

        // back-pressure fills the skid entry
        tick(); a_out_ready = 0; a_in_valid = 2'b11; a_in_data = 16'hA1A1;
        @(negedge clk); chk("bp_rdy_a1", 32'(a_in_ready), 1);
        tick(); a_in_data = 16'hA2A2;
        @(negedge clk); chk("bp_rdy_a2", 32'(a_in_ready), 1); chk("bp_out_a1", 32'(a_out_data), 16'hA1A1);
        tick(); a_in_data = 16'hA3A3;
        @(negedge clk); chk("bp_rdy_two", 32'(a_in_ready), 0);
        tick();
        @(negedge clk); chk("bp_rdy_hold", 32'(a_in_ready), 0);
        tick(); a_out_ready = 1;
        @(negedge clk); chk("bp_stall3", a_stall, 3); chk("bp_rdy_rel", 32'(a_in_ready), 0);
        chk("bp_head", 32'(a_out_data), 16'hA1A1);
        tick();
        @(negedge clk); chk("bp_rdy_rise", 32'(a_in_ready), 1); chk("bp_out_a2", 32'(a_out_data), 16'hA2A2);
        tick(); a_in_valid = 0;
        @(negedge clk); chk("bp_out_a3", 32'(a_out_data), 16'hA3A3);
        tick();
        @(negedge clk); chk("bp_empty", 32'(a_out_valid), 0); chk("bp_stall_end", a_stall, 3);

        // partial lanes
        tick(); a_in_valid = 2'b10; a_in_data = 16'hBBAA;
        tick(); a_in_valid = 0;
        @(negedge clk); chk("part_valid", 32'(a_out_valid), 2); chk("part_lane1", 32'(a_out_data[15:8]), 8'hBB);
        tick();

        // flush while in TWO with a bundle offered
        tick(); a_out_ready = 0; a_in_valid = 2'b11; a_in_data = 16'hC1C1;
        tick(); a_in_data = 16'hC2C2;
        tick(); a_in_data = 16'hC3C3; a_flush = 1;
        @(negedge clk); chk("fl_stall_before", a_stall, 4); chk("fl_out_valid_kept", 32'(a_out_valid), 3);
        tick(); a_flush = 0; a_in_valid = 0;
        @(negedge clk); chk("fl_valid", 32'(a_out_valid), 0); chk("fl_rdy", 32'(a_in_ready), 1);
        chk("fl_stall_after", a_stall, 4);

        // flush in EMPTY drops an acceptable bundle
        tick(); a_in_valid = 2'b11; a_in_data = 16'hD1D1; a_flush = 1;
        @(negedge clk); chk("fl2_rdy", 32'(a_in_ready), 1);
        tick(); a_flush = 0; a_in_valid = 0; a_out_ready = 1;
        @(negedge clk); chk("fl2_dropped", 32'(a_out_valid), 0);
        tick(); a_in_valid = 2'b11; a_in_data = 16'hE5E5;
        tick(); a_in_valid = 0;
        @(negedge clk); chk("recover", 32'(a_out_data), 16'hE5E5);
        tick(); tick();

        // SKID=0 with toggling out_ready
        for (int k = 0; k < 8; k++) begin
            tick();
            b_out_ready = b_or[k];
            b_in_valid  = b_iv[k] ? 2'b11 : 2'b00;
            b_in_data   = b_dat[k];
            @(negedge clk);
            chk($sformatf("b_rdy%0d", k), 32'(b_in_ready), 32'(b_rdy[k]));
        end
        tick(); b_out_ready = 0; b_in_valid = 0;
        @(negedge clk); chk("b_stall", b_stall, 3); chk("b_empty", 32'(b_out_valid), 0);

        chk("a_sb_drained", qa.size(), 0);
        chk("b_sb_drained", qb.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
